// File: rtl/serial_subtractor8_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width; guard keeps a 1-bit counter legal for tiny widths.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor8_if.sv
// Start/busy/done request bus for the bit-serial subtractor.
interface serial_subtractor8_if #(parameter int WIDTH = sub_pkg::WIDTH_DEF);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero, ovf
  );
endinterface

// File: rtl/serial_subtractor8_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor8.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock via one full_subtractor.
// SUB_SAT_EN: unsigned saturation (diff clamps to 0 on borrow out).
module serial_subtractor8
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor8_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q, zero_q, ovf_q;

  logic             d, brw_nx, last;
  logic [WIDTH-1:0] diff_nx, res;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .d    (d),
    .bout (brw_nx)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  // On the last bit the full result is the new MSB over the bits shifted in so far.
  assign diff_nx = {d, r_sr[WIDTH-1:1]};

`ifdef SUB_SAT_EN
  assign res = brw_nx ? '0 : diff_nx;
`else
  assign res = diff_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            brw   <= bus.bin;
            r_sr  <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          brw  <= brw_nx;
          r_sr <= diff_nx;
          cnt  <= cnt + 1'b1;
          if (last) begin
            state  <= DONE;
            diff_q <= res;
            bout_q <= brw_nx;
            zero_q <= (res == '0);
            // brw is the borrow into the MSB on this cycle.
            ovf_q  <= brw ^ brw_nx;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_subtractor8.md
# serial_subtractor8

Bit-serial two's-complement subtractor: computes A − B − Bin one bit per clock through a single full-subtractor cell. It is the sequential subtract counterpart to the team's combinational ripple-carry adder. It sits on the ALU datapath where area matters more than latency. A start/busy/done handshake lets it be driven by a control FSM.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥ 2).

Ports (reset is asynchronous and active-low):
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- bin  input  1  borrow-in; captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- diff  output  WIDTH  result; held until the next completion
- bout  output  1  borrow out of the MSB (unsigned A < B + Bin)
- zero  output  1  high when diff == 0
- ovf  output  1  signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, b and bin into the shift registers, clears the bit counter, and moves to RUN.
  - start=0 keeps the FSM in IDLE.
- RUN, each cycle:
  - The cell computes d = a_sr[0] ^ b_sr[0] ^ brw.
  - Next borrow: brw' = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw).
  - d shifts into the result register MSB; a_sr and b_sr shift right; the counter increments.
- On the cycle processing bit WIDTH−1:
  - Move to DONE.
  - Register diff, bout = brw', zero, and ovf.
  - ovf = borrow into the MSB XOR borrow out of the MSB.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- start in RUN or DONE is ignored; operands are not re-latched.
- Arithmetic wraps modulo 2^WIDTH; flags are computed on the final diff.
- Asynchronous reset at any point, including mid-RUN:
  - The FSM goes to IDLE; all registers clear.
  - Outputs read busy=0, done=0, diff=0, bout=0, zero=0, ovf=0.
  - The partial operation is discarded.

## Timing
- Edge 0: start sampled high in IDLE; the FSM enters RUN and busy rises.
- Edges 1..WIDTH: process bits 0..WIDTH−1.
- Edge WIDTH: diff and flags update; busy falls; done rises.
- Edge WIDTH+1: done falls; the FSM is back in IDLE.
- Earliest next accepted start: edge WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: SUB_SAT_EN.
- Defined:
  - Unsigned saturating mode: if bout=1, diff is forced to 0 and zero=1.
  - bout and ovf still report the raw borrow and overflow.
- Undefined: wrap-around result as described in Operation.

## Structure
- Package sub_pkg holds:
  - the state enum typedef (IDLE/RUN/DONE, 2-bit encoding);
  - the default WIDTH constant;
  - the counter width as a function of WIDTH (clog2).
- Sub-module full_subtractor, purely combinational:
  - inputs a, b, bin;
  - outputs d, bout;
  - one instance only.
- The top level holds the FSM, the shift registers, the borrow flop, the counter and the output registers.

## Test plan
All scenarios use WIDTH=8; "edge N" is counted from the edge where start is accepted.
- a=0x5A, b=0x23, bin=0 → diff=0x37, bout=0, zero=0, ovf=0.
  - busy is high edges 0..7; done pulses only in the cycle after edge 8.
- a=0x10, b=0x20, bin=0 → diff=0xF0, bout=1, ovf=0.
  - With SUB_SAT_EN: diff=0x00, zero=1.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1.
  - Separately: a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- a=0x42, b=0x41, bin=1 → diff=0x00, zero=1, bout=0.
  - Back-to-back: start held high continuously → each operation completes every 10 cycles.
- Start a=0x05, b=0x03; during RUN pulse start with a=0xFF, b=0x00 → ignored, diff=0x02.
- rst_n low at edge 4 of RUN → busy=0, done=0 and all outputs 0 immediately.
  - After release, a new start with a=0x09, b=0x04 gives diff=0x05.
